ifetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle MIPS datapath. It sits directly downstream of the PC register. It reads the current `pc` and fetches the word over a req/ack instruction-memory handshake, then presents it to decode as an instruction register with a valid/ready handshake. It also produces the `npc`/`pc_wr` pair that feeds back into the PC register: sequential `pc+4`, or a redirect target from branch/jump resolution.

---
 rtl/ifetch_unit.sv | 155 +++++++++++++++
 tb/tb_ifetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: fetches the word at pc over a req/ack memory port and hands it to decode as ir.
// Define FETCH_TIMEOUT_EN to fault after TIMEOUT consecutive unacknowledged request cycles.
module ifetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] npc,
    output logic        pc_wr,
    output logic        fault
);
    typedef enum logic [2:0] {IDLE, FETCH, VALID, DRAIN, FAULT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] pc_seq;
    logic        misaligned;
    logic        timeout_hit;
    logic        load_ir;
    logic        load_addr;

    assign pc_seq     = pc + 32'd4;
    assign misaligned = (pc[1:0] != 2'b00);

    // Request side is kept apart from the ack-dependent logic so imem_req never depends on imem_ack.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            FETCH:   imem_req = !misaligned;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_wr     = 1'b0;
        npc       = pc_seq;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    pc_wr = 1'b1;
                    npc   = redirect_pc;
                end
            end
            FETCH: begin
                if (misaligned) begin
                    state_nxt = FAULT;
                end else if (redirect) begin
                    pc_wr = 1'b1;
                    npc   = redirect_pc;
                    // An unacked request must still complete, so it is parked in DRAIN.
                    if (imem_ack) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = DRAIN;
                        load_addr = 1'b1;
                    end
                end else if (imem_ack) begin
                    state_nxt = VALID;
                    load_ir   = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = FAULT;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_wr     = 1'b1;
                    npc       = redirect_pc;
                    state_nxt = FETCH;
                end else if (ir_ready) begin
                    pc_wr     = 1'b1;
                    npc       = pc_seq;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_wr = 1'b1;
                    npc   = redirect_pc;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                end else if (timeout_hit) begin
                    state_nxt = FAULT;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ir       <= 32'd0;
            ir_pc    <= 32'd0;
            ir_valid <= 1'b0;
            addr_q   <= 32'd0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ir_valid <= (state_nxt == VALID);
            fault    <= (state_nxt == FAULT);
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
            if (load_addr) begin
                addr_q <= pc;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts the request cycles already spent waiting; the TIMEOUT-th unacked cycle faults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_nxt != state) || imem_ack || !imem_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus a randomized run checked against a program-order model.
`timescale 1ns/1ps
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] npc;
    logic        pc_wr;
    logic        fault;

    logic        mem_off;
    logic [7:0]  mem_wait;
    logic [7:0]  mem_lat;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Environment: memory with programmable wait states, and the PC register fed by npc/pc_wr.
    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && !mem_off && (mem_wait >= mem_lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_wait <= 8'd0;
        else if (!imem_req || imem_ack) mem_wait <= 8'd0;
        else mem_wait <= mem_wait + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'h0000_3000;
        else if (pc_wr) pc <= npc;
    end

    ifetch_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .npc(npc), .pc_wr(pc_wr), .fault(fault)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; ir_ready = 1'b0; mem_lat = 8'd0; mem_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        smp();
        vectors++; if (ir !== 32'd0) begin miscompares++; $display("FAIL reset_ir got=%h want=%h", ir, 32'd0); end
        vectors++; if (ir_pc !== 32'd0) begin miscompares++; $display("FAIL reset_ir_pc got=%h want=%h", ir_pc, 32'd0); end
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ir_valid got=%b want=0", ir_valid); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_imem_req got=%b want=0", imem_req); end
        vectors++; if (pc_wr !== 1'b0) begin miscompares++; $display("FAIL reset_pc_wr got=%b want=0", pc_wr); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got=%b want=0", fault); end
        vectors++; if (npc !== 32'h3004) begin miscompares++; $display("FAIL reset_npc got=%h want=%h", npc, 32'h3004); end
        cyc(); rst = 1'b0;
        smp();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_imem_req got=%b want=0", imem_req); end
        cyc();
        smp();
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_fetch_req got=%b want=1", imem_req); end
        vectors++; if (imem_addr !== 32'h3000) begin miscompares++; $display("FAIL first_fetch_addr got=%h want=%h", imem_addr, 32'h3000); end
        cyc();
        smp();
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL first_ir_valid got=%b want=1", ir_valid); end
        vectors++; if (ir !== 32'h2008_0005) begin miscompares++; $display("FAIL first_ir got=%h want=%h", ir, 32'h2008_0005); end
        vectors++; if (ir_pc !== 32'h3000) begin miscompares++; $display("FAIL first_ir_pc got=%h want=%h", ir_pc, 32'h3000); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL valid_imem_req got=%b want=0", imem_req); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            cyc(); ir_ready = 1'b0;
            smp();
            vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL stall_ir_valid[%0d] got=%b want=1", i, ir_valid); end
            vectors++; if (ir !== 32'h2008_0005) begin miscompares++; $display("FAIL stall_ir[%0d] got=%h want=%h", i, ir, 32'h2008_0005); end
            vectors++; if (pc_wr !== 1'b0) begin miscompares++; $display("FAIL stall_pc_wr[%0d] got=%b want=0", i, pc_wr); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_imem_req[%0d] got=%b want=0", i, imem_req); end
        end
    endtask

    task automatic test_sequential();
        cyc(); ir_ready = 1'b1;
        smp();
        vectors++; if (pc_wr !== 1'b1) begin miscompares++; $display("FAIL seq_pc_wr got=%b want=1", pc_wr); end
        vectors++; if (npc !== 32'h3004) begin miscompares++; $display("FAIL seq_npc got=%h want=%h", npc, 32'h3004); end
        cyc(); ir_ready = 1'b0;
        smp();
        vectors++; if (imem_addr !== 32'h3004) begin miscompares++; $display("FAIL seq_addr got=%h want=%h", imem_addr, 32'h3004); end
        cyc();
        smp();
        vectors++; if (ir_pc !== 32'h3004) begin miscompares++; $display("FAIL seq_ir_pc got=%h want=%h", ir_pc, 32'h3004); end
        vectors++; if (ir !== mem_word(32'h3004)) begin miscompares++; $display("FAIL seq_ir got=%h want=%h", ir, mem_word(32'h3004)); end
        cyc(); ir_ready = 1'b1; mem_lat = 8'd3;
        smp();
        vectors++; if (npc !== 32'h3008) begin miscompares++; $display("FAIL seq_npc2 got=%h want=%h", npc, 32'h3008); end
    endtask

    task automatic test_redirect_outstanding();
        cyc(); ir_ready = 1'b0;
        smp();
        vectors++; if (imem_addr !== 32'h3008) begin miscompares++; $display("FAIL rdo_addr0 got=%h want=%h", imem_addr, 32'h3008); end
        cyc(); redirect = 1'b1; redirect_pc = 32'h3100;
        smp();
        vectors++; if (pc_wr !== 1'b1) begin miscompares++; $display("FAIL rdo_pc_wr got=%b want=1", pc_wr); end
        vectors++; if (npc !== 32'h3100) begin miscompares++; $display("FAIL rdo_npc got=%h want=%h", npc, 32'h3100); end
        for (int i = 0; i < 2; i++) begin
            cyc(); redirect = 1'b0;
            smp();
            vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rdo_drain_req[%0d] got=%b want=1", i, imem_req); end
            vectors++; if (imem_addr !== 32'h3008) begin miscompares++; $display("FAIL rdo_drain_addr[%0d] got=%h want=%h", i, imem_addr, 32'h3008); end
            vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rdo_drain_valid[%0d] got=%b want=0", i, ir_valid); end
        end
        cyc(); mem_lat = 8'd0;
        smp();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rdo_discard_valid got=%b want=0", ir_valid); end
        vectors++; if (imem_addr !== 32'h3100) begin miscompares++; $display("FAIL rdo_next_addr got=%h want=%h", imem_addr, 32'h3100); end
        cyc();
        smp();
        vectors++; if (ir_pc !== 32'h3100) begin miscompares++; $display("FAIL rdo_ir_pc got=%h want=%h", ir_pc, 32'h3100); end
        vectors++; if (ir !== mem_word(32'h3100)) begin miscompares++; $display("FAIL rdo_ir got=%h want=%h", ir, mem_word(32'h3100)); end
    endtask

    task automatic test_redirect_ack();
        cyc(); ir_ready = 1'b1;
        smp();
        cyc(); ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3200;
        smp();
        vectors++; if (npc !== 32'h3200) begin miscompares++; $display("FAIL rda_npc got=%h want=%h", npc, 32'h3200); end
        vectors++; if (imem_addr !== 32'h3104) begin miscompares++; $display("FAIL rda_addr got=%h want=%h", imem_addr, 32'h3104); end
        cyc(); redirect = 1'b0;
        smp();
        vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rda_valid got=%b want=0", ir_valid); end
        vectors++; if (ir_pc !== 32'h3100) begin miscompares++; $display("FAIL rda_ir_pc_kept got=%h want=%h", ir_pc, 32'h3100); end
        vectors++; if (imem_addr !== 32'h3200) begin miscompares++; $display("FAIL rda_next_addr got=%h want=%h", imem_addr, 32'h3200); end
        cyc();
        smp();
        vectors++; if (ir_pc !== 32'h3200) begin miscompares++; $display("FAIL rda_ir_pc got=%h want=%h", ir_pc, 32'h3200); end
    endtask

    task automatic test_wrap();
        cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        smp();
        cyc(); redirect = 1'b0;
        smp();
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got=%h want=%h", imem_addr, 32'hFFFF_FFFC); end
        cyc();
        smp();
        cyc(); ir_ready = 1'b1;
        smp();
        vectors++; if (npc !== 32'd0) begin miscompares++; $display("FAIL wrap_npc got=%h want=%h", npc, 32'd0); end
        cyc(); ir_ready = 1'b0;
        smp();
        vectors++; if (imem_addr !== 32'd0) begin miscompares++; $display("FAIL wrap_next_addr got=%h want=%h", imem_addr, 32'd0); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h3002;
        smp();
        vectors++; if (npc !== 32'h3002) begin miscompares++; $display("FAIL mis_npc got=%h want=%h", npc, 32'h3002); end
        cyc(); redirect = 1'b0;
        smp();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req got=%b want=0", imem_req); end
        for (int i = 0; i < 6; i++) begin
            cyc(); redirect = 1'b1; redirect_pc = 32'h3000 + 32'($urandom_range(0, 255)) * 4; ir_ready = 1'b1;
            smp();
            vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault[%0d] got=%b want=1", i, fault); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_fault_req[%0d] got=%b want=0", i, imem_req); end
            vectors++; if (pc_wr !== 1'b0) begin miscompares++; $display("FAIL mis_fault_pc_wr[%0d] got=%b want=0", i, pc_wr); end
            vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL mis_fault_valid[%0d] got=%b want=0", i, ir_valid); end
        end
        cyc(); redirect = 1'b0; ir_ready = 1'b0; rst = 1'b1;
        #1;
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL mis_async_clear got=%b want=0", fault); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        apply_reset();
        mem_off = 1'b1; rst = 1'b0; n = 0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (fault) break;
            if (imem_req) n++;
            cyc();
        end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL timeout_fault got=%b want=1", fault); end
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL timeout_cycles got=%0d want=16", n); end
        apply_reset();
        mem_off = 1'b1; rst = 1'b0; n = 0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (imem_req) n++;
            if (n == 15) begin mem_off = 1'b0; break; end
            cyc();
        end
        cyc();
        smp();
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL timeout_ack15_valid got=%b want=1", ir_valid); end
        repeat (20) cyc();
        smp();
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL timeout_ack15_fault got=%b want=0", fault); end
    endtask
`endif

    // Program-order model: decode must see consecutive words, restarting at the latest redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        logic        prev_redirect, prev_pend;
        int          delivered;
        apply_reset();
        rst = 1'b0;
        exp_pc = 32'h3000; prev_redirect = 1'b0; prev_pend = 1'b0; prev_addr = 32'd0; delivered = 0;
        for (int i = 0; i < 800; i++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            else redirect_pc = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
            mem_lat = 8'($urandom_range(0, 3));
            smp();
            vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rnd_fault[%0d] got=%b want=0", i, fault); end
            if (prev_redirect) begin
                vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush[%0d] got=%b want=0", i, ir_valid); end
            end
            if (prev_pend) begin
                vectors++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin miscompares++; $display("FAIL rnd_req_stable[%0d] got=%b/%h want=1/%h", i, imem_req, imem_addr, prev_addr); end
            end
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (ir_valid && ir_ready) begin
                vectors++; if (ir_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_ir_pc[%0d] got=%h want=%h", i, ir_pc, exp_pc); end
                vectors++; if (ir !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rnd_ir[%0d] got=%h want=%h", i, ir, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_redirect = redirect;
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            cyc();
        end
        vectors++; if (delivered < 50) begin miscompares++; $display("FAIL rnd_progress got=%0d want>=50", delivered); end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; ir_ready = 1'b0; mem_lat = 8'd0; mem_off = 1'b0;
        test_reset();
        test_stall();
        test_sequential();
        test_redirect_outstanding();
        test_redirect_ack();
        test_wrap();
        test_misaligned();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
